// File: rtl/fft_iter_pkg.sv
// Shared types and helpers for the iterative FFT input path.
package fft_iter_pkg;

    localparam int IWL_DEF = 32;
    localparam int AWL_DEF = 5;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KICK,
        ST_STRT,
        ST_WBUSY,
        ST_WFREE
    } ld_state_t;

    // Reverse the low w bits of v. Only constant bit indices are used, so the
    // double loop folds to plain wiring.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                if (i < w && i + j == w - 1) r[i] = v[j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse_unit.sv
// Address mapping for one input-RAM port. FFT_LOADER_BITREV_EN selects
// bit-reversed order; without it the index passes through unchanged.
module bit_reverse_unit
    import fft_iter_pkg::*;
#(
    parameter int AWL = AWL_DEF
) (
    input  logic [AWL-1:0] idx_i,
    output logic [AWL-1:0] addr_o
);

`ifdef FFT_LOADER_BITREV_EN
    assign addr_o = AWL'(bitrev(32'(idx_i), AWL));
`else
    assign addr_o = idx_i;
`endif

endmodule

// File: rtl/fft_input_loader.sv
// Streams samples pairwise into the FFT engine's input RAM, then starts the
// engine and waits for it to release the RAM. Order set by FFT_LOADER_BITREV_EN.
module fft_input_loader
    import fft_iter_pkg::*;
#(
    parameter int IWL = IWL_DEF,
    parameter int AWL = AWL_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           S_VALID,
    output logic           S_READY,
    input  logic [IWL-1:0] S_DATA,
    input  logic           I_RAM_BLOCK,
    output logic           O_START,
    output logic           O_RAM_WR,
    output logic [IWL-1:0] O_A_ADDR,
    output logic [IWL-1:0] O_B_ADDR,
    output logic [IWL-1:0] O_A_DATA,
    output logic [IWL-1:0] O_B_DATA,
    output logic           O_BUSY
);

    localparam logic [AWL-1:0] CNT_LAST = '1;

    ld_state_t      state_q, state_d;
    logic [AWL-1:0] cnt_q, cnt_d;
    logic [IWL-1:0] hold_q, hold_d;
    logic           wr_q, wr_d, start_q, start_d, busy_q, busy_d;
    logic [AWL-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [IWL-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic [AWL-1:0] rev_a, rev_b;
    logic           xfer;

    // Port A always takes the even index of the pair, port B the odd one.
    bit_reverse_unit #(.AWL(AWL)) u_rev_a (.idx_i(cnt_q & ~AWL'(1)), .addr_o(rev_a));
    bit_reverse_unit #(.AWL(AWL)) u_rev_b (.idx_i(cnt_q),            .addr_o(rev_b));

    // Reset also blocks acceptance so nothing is handshaken while held in reset.
    assign S_READY = RST && (state_q == ST_LOAD) && !I_RAM_BLOCK;
    assign xfer    = S_VALID && S_READY;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        wr_d     = 1'b0;
        start_d  = 1'b0;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q + AWL'(1);
                    if (!cnt_q[0]) begin
                        hold_d = S_DATA;
                    end else begin
                        wr_d     = 1'b1;
                        a_addr_d = rev_a;
                        b_addr_d = rev_b;
                        a_data_d = hold_q;
                        b_data_d = S_DATA;
                    end
                    if (cnt_q == CNT_LAST) state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                state_d = ST_STRT;
                start_d = 1'b1;
            end
            ST_STRT:  state_d = ST_WBUSY;
            ST_WBUSY: if (I_RAM_BLOCK)  state_d = ST_WFREE;
            ST_WFREE: if (!I_RAM_BLOCK) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
        busy_d = (state_d != ST_LOAD);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            hold_q   <= '0;
            wr_q     <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            wr_q     <= wr_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
        end
    end

    assign O_START  = start_q;
    assign O_RAM_WR = wr_q;
    assign O_BUSY   = busy_q;
    assign O_A_ADDR = {{(IWL-AWL){1'b0}}, a_addr_q};
    assign O_B_ADDR = {{(IWL-AWL){1'b0}}, b_addr_q};
    assign O_A_DATA = a_data_q;
    assign O_B_DATA = b_data_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized self-checking bench for fft_input_loader against a frame-level model.
module tb_fft_input_loader;

    localparam int IWL = 32;
    localparam int AWL = 5;
    localparam int N   = 1 << AWL;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           S_VALID = 1'b0;
    logic           S_READY;
    logic [IWL-1:0] S_DATA = '0;
    logic           I_RAM_BLOCK = 1'b0;
    logic           O_START, O_RAM_WR, O_BUSY;
    logic [IWL-1:0] O_A_ADDR, O_B_ADDR, O_A_DATA, O_B_DATA;

    fft_input_loader #(.IWL(IWL), .AWL(AWL)) dut (
        .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .I_RAM_BLOCK(I_RAM_BLOCK), .O_START(O_START), .O_RAM_WR(O_RAM_WR),
        .O_A_ADDR(O_A_ADDR), .O_B_ADDR(O_B_ADDR), .O_A_DATA(O_A_DATA),
        .O_B_DATA(O_B_DATA), .O_BUSY(O_BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected RAM address for frame position i.
    function automatic int unsigned addr_of(input int unsigned i);
        int unsigned r;
`ifdef FFT_LOADER_BITREV_EN
        r = 0;
        for (int b = 0; b < AWL; b++) r = r + (((i / (1 << b)) % 2) * (1 << (AWL - 1 - b)));
`else
        r = i;
`endif
        return r;
    endfunction

    // Frame-level model: samples of the current frame, loader free/waiting
    // phase, and the outputs predicted for the next cycle.
    logic [IWL-1:0] frame_q[$];
    bit             armed = 0;
    bit             m_load = 1;
    int             gap = 0;
    bit             seen_hi = 0;
    bit             exp_wr = 0, exp_start = 0, exp_busy = 0;
    int unsigned    exp_aa, exp_ba;
    logic [IWL-1:0] exp_ad, exp_bd;
    int             wr_cnt = 0;

    always @(negedge CLK) begin
        if (armed) begin
            chk("ram_wr", O_RAM_WR, exp_wr);
            if (exp_wr) begin
                chk("a_addr", O_A_ADDR, exp_aa);
                chk("b_addr", O_B_ADDR, exp_ba);
                chk("a_data", O_A_DATA, exp_ad);
                chk("b_data", O_B_DATA, exp_bd);
            end
            chk("start", O_START, exp_start);
            chk("busy", O_BUSY, exp_busy);
        end
        if (armed || !RST) chk("s_ready", S_READY, RST && m_load && !I_RAM_BLOCK);
        if (armed && O_RAM_WR) wr_cnt++;

        exp_wr    = 0;
        exp_start = 0;
        if (!RST) begin
            armed  = 1;
            m_load = 1;
            frame_q.delete();
        end else if (m_load) begin
            if (S_VALID && !I_RAM_BLOCK) begin
                frame_q.push_back(S_DATA);
                if (frame_q.size() % 2 == 0) begin
                    exp_wr = 1;
                    exp_aa = addr_of(frame_q.size() - 2);
                    exp_ba = addr_of(frame_q.size() - 1);
                    exp_ad = frame_q[frame_q.size() - 2];
                    exp_bd = frame_q[frame_q.size() - 1];
                end
                if (frame_q.size() == N) begin
                    frame_q.delete();
                    m_load  = 0;
                    gap     = 0;
                    seen_hi = 0;
                end
            end
        end else begin
            // Start follows the final write; the busy flag is only honoured
            // from the third edge after the last sample.
            if (gap == 0) exp_start = 1;
            if (gap < 2) gap++;
            else if (!seen_hi) seen_hi = I_RAM_BLOCK;
            else if (!I_RAM_BLOCK) m_load = 1;
        end
        exp_busy = !m_load;
    end

    task automatic send_samples(input int n, input bit gaps, input bit ramp, input int blk_at);
        int acc = 0;
        int cyc = 0;
        int blk_cnt = 0;
        while (acc < n && cyc < 2000) begin
            @(posedge CLK); #1;
            S_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            S_DATA  = ramp ? IWL'(acc) : IWL'($urandom);
            if (blk_at >= 0 && acc >= blk_at && blk_cnt < 4) begin
                I_RAM_BLOCK = 1'b1;
                blk_cnt++;
            end else begin
                I_RAM_BLOCK = 1'b0;
            end
            @(negedge CLK);
            if (S_VALID && S_READY) acc++;
            cyc++;
        end
        if (acc < n) chk("send_timeout", acc, n);
        @(posedge CLK); #1;
        S_VALID = 1'b0;
        I_RAM_BLOCK = 1'b0;
    endtask

    task automatic finish_frame();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!O_START && n < 40);
        chk("start_seen", O_START, 1);
        repeat (3) @(posedge CLK);
        #1 I_RAM_BLOCK = 1'b1;
        repeat (20) @(posedge CLK);
        #1 I_RAM_BLOCK = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!S_READY && n < 10);
        chk("ready_after_free", S_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int wr0;

    initial begin
        // Reset held with a valid sample offered.
        RST = 1'b0;
        S_VALID = 1'b1;
        S_DATA = 32'hdead_beef;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", S_READY, 0);
        chk("rst_wr", O_RAM_WR, 0);
        chk("rst_start", O_START, 0);
        chk("rst_busy", O_BUSY, 0);
        chk("rst_a_addr", O_A_ADDR, 0);
        chk("rst_b_addr", O_B_ADDR, 0);
        chk("rst_a_data", O_A_DATA, 0);
        chk("rst_b_data", O_B_DATA, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        S_VALID = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", S_READY, 1);

        // Ramp frame, back-to-back.
        wr0 = wr_cnt;
        send_samples(N, 0, 1, -1);
        finish_frame();
        chk("wr_pulses_ramp", wr_cnt - wr0, N / 2);

        // Random gaps plus a 4-cycle block mid-load.
        wr0 = wr_cnt;
        send_samples(N, 1, 0, 10);
        finish_frame();
        chk("wr_pulses_bp", wr_cnt - wr0, N / 2);

        // Partial frame aborted by reset; held sample 4 must be dropped.
        wr0 = wr_cnt;
        send_samples(5, 0, 0, -1);
        RST = 1'b0;
        S_VALID = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1;
        S_VALID = 1'b0;
        @(negedge CLK);
        chk("wr_pulses_abort", wr_cnt - wr0, 2);

        wr0 = wr_cnt;
        send_samples(N, 1, 0, -1);
        finish_frame();
        chk("wr_pulses_after_rst", wr_cnt - wr0, N / 2);

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
